// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding imem read feeding a small decoder buffer.
// Define FETCH_PREFETCH_EN for a 2-entry buffer; otherwise the buffer holds 1 entry.
module instruction_fetch #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [7:0]          imem_rdata,
    output logic [7:0]          instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                halt
);

    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(RESET_PC);
`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] fetch_pc, pc_nx, addr_nx, pc_inc;
    logic [1:0]          count, count_nx;
    logic                rd_ptr, wr_ptr;
    logic                push, pop, space;
    logic [7:0]          ent_data [2];
    logic [PC_WIDTH-1:0] ent_pc   [2];

    function automatic logic ptr_inc(input logic p);
        return (DEPTH == 2'd2) ? ~p : 1'b0;
    endfunction

    assign instr_valid = (count != 2'd0);
    assign instr       = ent_data[rd_ptr];
    assign instr_pc    = ent_pc[rd_ptr];

    always_comb begin
        pop      = instr_valid & instr_ready & ~branch_taken;
        push     = (state == REQ) & imem_ack & ~branch_taken;
        count_nx = count + {1'b0, push} - {1'b0, pop};
        space    = (count_nx < DEPTH);
        pc_inc   = fetch_pc + PC_WIDTH'(1);
        state_nx = state;
        pc_nx    = fetch_pc;
        addr_nx  = imem_addr;
        if (branch_taken) begin
            pc_nx = branch_target;
            // A read still in flight must be drained before the new address goes out.
            if (state != IDLE && !imem_ack) begin
                state_nx = DISCARD;
            end else begin
                state_nx = halt ? IDLE : REQ;
                addr_nx  = branch_target;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (!halt && space) state_nx = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_nx    = pc_inc;
                        addr_nx  = pc_inc;
                        state_nx = (!halt && space) ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        addr_nx  = fetch_pc;
                        state_nx = (!halt && space) ? REQ : IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            fetch_pc    <= START_PC;
            imem_addr   <= START_PC;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            ent_data[0] <= 8'd0;
            ent_data[1] <= 8'd0;
            ent_pc[0]   <= '0;
            ent_pc[1]   <= '0;
        end else begin
            state     <= state_nx;
            imem_req  <= (state_nx != IDLE);
            fetch_pc  <= pc_nx;
            imem_addr <= addr_nx;
            if (branch_taken) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                count <= count_nx;
                if (push) begin
                    ent_data[wr_ptr] <= imem_rdata;
                    ent_pc[wr_ptr]   <= imem_addr;
                    wr_ptr           <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios push expected
// (pc, instr) pairs; a monitor pops and compares on every decoder transfer.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req, imem_ack;
    logic [7:0] imem_addr, imem_rdata;
    logic [7:0] instr, instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'd0;
    logic       halt = 1'b0;
    logic       auto_ack = 1'b0;
    logic       man_ack = 1'b0;
    logic [7:0] man_data = 8'd0;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   acks  = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [7:0] a);
        return a + 8'h1A;
    endfunction

    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = auto_ack ? mem_byte(imem_addr) : man_data;

    instruction_fetch #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && instr_valid && instr_ready && !branch_taken && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("xfer_pc", int'(instr_pc), int'(e.pc));
            chk("xfer_instr", int'(instr), int'(e.data));
        end
        if (imem_req && imem_ack) acks++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] pc, input logic [7:0] data);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic h, input logic aa, input logic rdy);
        rst           = 1'b1;
        halt          = h;
        auto_ack      = aa;
        man_ack       = 1'b0;
        instr_ready   = rdy;
        branch_taken  = 1'b0;
        branch_target = 8'd0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_req", int'(imem_req), 0);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_instr", int'(instr), 0);
        chk("rst_pc", int'(instr_pc), 0);
        step();
        rst  = 1'b0;
        acks = 0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic branch_to(input logic [7:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
        step();
        branch_taken  = 1'b0;
    endtask

    initial begin
        // sequential stream from reset
        do_reset(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) push_exp(8'(i), 8'h1A + 8'(i));
`ifdef FETCH_PREFETCH_EN
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("stream_req", int'(imem_req), 1);
            chk("stream_addr", int'(imem_addr), i);
        end
`endif
        wait_drain("stream_drain");

        // decoder stall
        do_reset(1'b0, 1'b1, 1'b0);
        repeat (8) step();
        @(negedge clk);
        chk("stall_acks", acks, DEPTH);
        chk("stall_req", int'(imem_req), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(instr_valid), 1);
            chk("stall_pc", int'(instr_pc), 8'h00);
            chk("stall_instr", int'(instr), 8'h1A);
        end
        auto_ack = 1'b0;
        push_exp(8'h00, 8'h1A);
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        wait_drain("stall_drain");

        // branch over an in-flight read, then a double branch in DISCARD
        do_reset(1'b1, 1'b0, 1'b1);
        halt = 1'b0;
        branch_to(8'h05);
        @(negedge clk);
        chk("br_req", int'(imem_req), 1);
        chk("br_addr5", int'(imem_addr), 8'h05);
        branch_to(8'h40);
        @(negedge clk);
        chk("disc_addr", int'(imem_addr), 8'h05);
        chk("disc_req", int'(imem_req), 1);
        step();
        man_ack  = 1'b1;
        man_data = 8'hFF;
        step();
        man_ack = 1'b0;
        @(negedge clk);
        chk("br_addr40", int'(imem_addr), 8'h40);
        chk("br_nodata", int'(instr_valid), 0);
        branch_to(8'h60);
        branch_to(8'h70);
        @(negedge clk);
        chk("dbl_addr", int'(imem_addr), 8'h40);
        push_exp(8'h70, 8'h5C);
        man_ack  = 1'b1;
        man_data = 8'hFF;
        step();
        man_ack = 1'b0;
        @(negedge clk);
        chk("dbl_addr70", int'(imem_addr), 8'h70);
        man_ack  = 1'b1;
        man_data = 8'h5C;
        step();
        man_ack = 1'b0;
        wait_drain("br_drain");

        // PC wrap
        do_reset(1'b1, 1'b1, 1'b1);
        push_exp(8'hFE, 8'h18);
        push_exp(8'hFF, 8'h19);
        push_exp(8'h00, 8'h1A);
        halt = 1'b0;
        branch_to(8'hFE);
        @(negedge clk);
        chk("wrap_addr", int'(imem_addr), 8'hFE);
        wait_drain("wrap_drain");

        // halt lets the outstanding read finish
        do_reset(1'b1, 1'b0, 1'b1);
        halt = 1'b0;
        branch_to(8'h10);
        halt = 1'b1;
        @(negedge clk);
        chk("halt_req", int'(imem_req), 1);
        step();
        @(negedge clk);
        chk("halt_keep", int'(imem_addr), 8'h10);
        push_exp(8'h10, 8'h33);
        man_ack  = 1'b1;
        man_data = 8'h33;
        step();
        man_ack = 1'b0;
        @(negedge clk);
        chk("halt_idle", int'(imem_req), 0);
        step();
        @(negedge clk);
        chk("halt_idle2", int'(imem_req), 0);
        push_exp(8'h11, 8'h44);
        halt = 1'b0;
        step();
        @(negedge clk);
        chk("resume_req", int'(imem_req), 1);
        chk("resume_addr", int'(imem_addr), 8'h11);
        man_ack  = 1'b1;
        man_data = 8'h44;
        step();
        man_ack = 1'b0;
        wait_drain("halt_drain");

        // reset abandons a read; late ack is ignored
        do_reset(1'b1, 1'b0, 1'b1);
        halt = 1'b0;
        branch_to(8'h22);
        @(negedge clk);
        chk("mid_addr", int'(imem_addr), 8'h22);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", int'(imem_req), 0);
        chk("mid_rst_addr", int'(imem_addr), 0);
        step();
        rst      = 1'b0;
        man_ack  = 1'b1;
        man_data = 8'hEE;
        @(negedge clk);
        chk("late_req", int'(imem_req), 0);
        step();
        man_ack = 1'b0;
        @(negedge clk);
        chk("refetch_req", int'(imem_req), 1);
        chk("refetch_addr", int'(imem_addr), 0);
        chk("late_valid", int'(instr_valid), 0);
        push_exp(8'h00, 8'h1A);
        man_ack  = 1'b1;
        man_data = 8'h1A;
        step();
        man_ack = 1'b0;
        wait_drain("refetch_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PC_WIDTH SHALL default to 8 and set the program-counter and memory-address width.
REQ-002 Parameter RESET_PC SHALL default to 0 and set the first fetch address after reset.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port imem_req  output  1  SHALL request an instruction-memory read.
REQ-006 Port imem_addr  output  PC_WIDTH  SHALL carry the address of the outstanding read.
REQ-007 Port imem_ack  input  1  SHALL indicate imem_rdata is valid for the outstanding read.
REQ-008 Port imem_rdata  input  8  SHALL carry the fetched instruction byte.
REQ-009 Port instr  output  8  SHALL carry the instruction presented to the decoder.
REQ-010 Port instr_pc  output  PC_WIDTH  SHALL carry the address of instr.
REQ-011 Port instr_valid  output  1  SHALL indicate instr/instr_pc are valid.
REQ-012 Port instr_ready  input  1  SHALL indicate the decoder consumes instr this cycle.
REQ-013 Port branch_taken  input  1  SHALL request a redirect to branch_target.
REQ-014 Port branch_target  input  PC_WIDTH  SHALL carry the redirect address.
REQ-015 Port halt  input  1  SHALL suppress issue of new memory requests while high.

Function
REQ-016 FSM states SHALL be IDLE (no request), REQ (imem_req=1, waiting ack), DISCARD (imem_req=1, response to be dropped).
REQ-017 imem_addr SHALL equal fetch PC and stay stable while imem_req=1 until imem_ack.
REQ-018 Transfer to decoder SHALL occur on any cycle with instr_valid=1 and instr_ready=1; instr/instr_pc SHALL hold while instr_valid=1 and instr_ready=0.
REQ-019 On imem_ack in REQ, imem_rdata and imem_addr SHALL be written to the buffer at that edge; fetch PC SHALL increment by 1, wrapping 2^PC_WIDTH-1 -> 0.
REQ-020 IDLE->REQ SHALL occur when halt=0 and the buffer will have a free entry next cycle; otherwise stay IDLE.
REQ-021 REQ after ack SHALL stay REQ (back-to-back, imem_req continuously high) if halt=0 and space remains, else go IDLE.
REQ-022 branch_taken=1 SHALL, at that edge, flush all buffered entries (instr_valid=0 next cycle), set fetch PC to branch_target, and go DISCARD if in REQ without imem_ack, else REQ (halt=0) or IDLE (halt=1).
REQ-023 branch_taken and imem_ack in the same cycle SHALL drop the acked data; branch wins over any decoder transfer that cycle.
REQ-024 In DISCARD, imem_addr SHALL keep the old address; on imem_ack data SHALL be dropped and state SHALL go REQ with imem_addr=branch_target (or IDLE if halt=1).
REQ-025 A second branch_taken in DISCARD SHALL update fetch PC only; the single outstanding response is still dropped.
REQ-026 halt SHALL never abort an outstanding request; the in-flight ack SHALL complete normally.
REQ-027 At most one memory request SHALL be outstanding at any time.

Reset
REQ-028 While rst=1: state IDLE, fetch PC=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-029 First rising edge after rst deasserts with halt=0 SHALL enter REQ, raising imem_req with imem_addr=RESET_PC.
REQ-030 rst mid-request SHALL abandon the request; a late imem_ack while IDLE SHALL be ignored.

Configuration
REQ-031 Macro FETCH_PREFETCH_EN defined SHALL give a 2-entry FIFO buffer; the next fetch issues while one entry is held, and a stalled decoder never stops a fetch into the free entry.
REQ-032 Without FETCH_PREFETCH_EN the buffer SHALL be 1 entry; a request issues only when the entry is empty or being consumed that cycle.

Verification
REQ-033 Reset, memory acks same cycle, instr_ready=1 -> imem_addr 0,1,2,3 consecutive cycles; instr_pc follows one cycle later; byte 0x1A at addr 0 appears as instr=0x1A.
REQ-034 instr_ready=0 for 5 cycles -> instr/instr_pc held constant; with FETCH_PREFETCH_EN exactly 2 entries fetched then imem_req=0; without, 1 entry.
REQ-035 branch_taken with target 0x40 while REQ at addr 0x05, ack 2 cycles later with 0xFF -> 0xFF never valid; next imem_addr=0x40.
REQ-036 PC_WIDTH=8, start at 0xFE -> fetches 0xFE, 0xFF, 0x00.
REQ-037 halt=1 asserted in REQ at addr 0x10 -> that ack accepted, imem_req=0 after; deassert -> resumes at 0x11.
REQ-038 rst pulsed during REQ at 0x22, ack arrives in reset-IDLE cycle -> data ignored; refetch starts at RESET_PC.
